// File: rtl/cr_huf_comp_sc_packer.sv
// Symbol-count packer: run-length merges an input symbol stream into (sym,cnt) lanes,
// packs four lanes per beat toward the Huffman symbol counter, and closes each block with an eob beat.
module cr_huf_comp_sc_packer #(
    parameter int DAT_WIDTH      = 10,
    parameter int CNT_WIDTH      = 3,
    parameter int CNTRL_WIDTH    = 1,
    parameter int NUM_IN_SYMBOLS = 4,
    parameter int SEQID_WIDTH    = 8,
    parameter int EOB_WIDTH      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [DAT_WIDTH-1:0]   in_sym,
    input  logic [EOB_WIDTH-1:0]   in_eob,
    input  logic [SEQID_WIDTH-1:0] in_seq_id,
    input  logic [CNTRL_WIDTH-1:0] in_meta,
    output logic [3:0]             sc_is_vld,
    output logic [DAT_WIDTH-1:0]   sc_is_sym0,
    output logic [DAT_WIDTH-1:0]   sc_is_sym1,
    output logic [DAT_WIDTH-1:0]   sc_is_sym2,
    output logic [DAT_WIDTH-1:0]   sc_is_sym3,
    output logic [CNT_WIDTH-1:0]   sc_is_cnt0,
    output logic [CNT_WIDTH-1:0]   sc_is_cnt1,
    output logic [CNT_WIDTH-1:0]   sc_is_cnt2,
    output logic [CNT_WIDTH-1:0]   sc_is_cnt3,
    output logic [SEQID_WIDTH-1:0] sc_is_seq_id,
    output logic [CNTRL_WIDTH-1:0] sc_is_meta,
    output logic [EOB_WIDTH-1:0]   sc_is_eob,
    input  logic                   is_sc_rd
);
    localparam int LANES = NUM_IN_SYMBOLS;
    localparam logic [EOB_WIDTH-1:0] EOB_MIDDLE = {EOB_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {ACC = 2'd0, EOB_CLOSE = 2'd1, EOB_SEND = 2'd2} state_t;

    state_t                 state, state_nxt;
    logic                   run_vld;
    logic [DAT_WIDTH-1:0]   run_sym;
    logic [CNT_WIDTH-1:0]   run_cnt;
    logic [DAT_WIDTH-1:0]   pack_sym [LANES];
    logic [CNT_WIDTH-1:0]   pack_cnt [LANES];
    logic [2:0]             fill;
    logic [3:0]             out_vld;
    logic [DAT_WIDTH-1:0]   out_sym [LANES];
    logic [CNT_WIDTH-1:0]   out_cnt [LANES];
    logic [EOB_WIDTH-1:0]   out_eob;
    logic [SEQID_WIDTH-1:0] out_seq, blk_seq;
    logic [CNTRL_WIDTH-1:0] out_meta, blk_meta;
    logic                   blk_first;
    logic [EOB_WIDTH-1:0]   eob_lat;

    logic       out_free, pack_move, accept, merge, close;
    logic [2:0] base, fill_nxt;

    always_comb begin
        out_free  = (out_vld == 4'b0000) | is_sc_rd;
        pack_move = out_free & ((state == EOB_SEND) | (fill == 3'(LANES)));
        in_rdy    = ~rst & (state == ACC) & ((fill < 3'(LANES)) | pack_move);
        accept    = in_vld & in_rdy;
        merge     = accept & run_vld & (in_sym == run_sym) & (run_cnt < CNT_MAX);
        close     = (accept & run_vld & ~merge) |
                    ((state == EOB_CLOSE) & ((fill < 3'(LANES)) | pack_move));
        // a lane closing alongside a pack move lands in lane 0 of the emptied pack
        base      = pack_move ? 3'd0 : fill;
        fill_nxt  = base + {2'b00, close};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:       if (accept && (in_eob != EOB_MIDDLE)) state_nxt = EOB_CLOSE;
                       else                                  state_nxt = ACC;
            EOB_CLOSE: if (close)     state_nxt = EOB_SEND;
                       else           state_nxt = EOB_CLOSE;
            EOB_SEND:  if (pack_move) state_nxt = ACC;
                       else           state_nxt = EOB_SEND;
            default:   state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_vld <= 1'b0;
            run_sym <= {DAT_WIDTH{1'b0}};
            run_cnt <= {CNT_WIDTH{1'b0}};
        end else if (accept) begin
            run_vld <= 1'b1;
            run_sym <= in_sym;
            run_cnt <= merge ? run_cnt + CNT_WIDTH'(1) : CNT_WIDTH'(1);
        end else if (close) begin
            run_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= 3'd0;
            for (int i = 0; i < LANES; i++) begin
                pack_sym[i] <= {DAT_WIDTH{1'b0}};
                pack_cnt[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            fill <= fill_nxt;
            if (close) begin
                pack_sym[base[1:0]] <= run_sym;
                pack_cnt[base[1:0]] <= run_cnt;
            end
        end
    end

    // lanes at or above the fill count are forced to zero on the way out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 4'b0000;
            out_eob  <= EOB_MIDDLE;
            out_seq  <= {SEQID_WIDTH{1'b0}};
            out_meta <= {CNTRL_WIDTH{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                out_sym[i] <= {DAT_WIDTH{1'b0}};
                out_cnt[i] <= {CNT_WIDTH{1'b0}};
            end
        end else if (pack_move) begin
            out_eob  <= (state == EOB_SEND) ? eob_lat : EOB_MIDDLE;
            out_seq  <= blk_seq;
            out_meta <= blk_meta;
            for (int i = 0; i < LANES; i++) begin
                out_vld[i] <= (3'(i) < fill);
                out_sym[i] <= (3'(i) < fill) ? pack_sym[i] : {DAT_WIDTH{1'b0}};
                out_cnt[i] <= (3'(i) < fill) ? pack_cnt[i] : {CNT_WIDTH{1'b0}};
            end
        end else if (is_sc_rd && (out_vld != 4'b0000)) begin
            out_vld <= 4'b0000;
            out_eob <= EOB_MIDDLE;
            for (int i = 0; i < LANES; i++) begin
                out_sym[i] <= {DAT_WIDTH{1'b0}};
                out_cnt[i] <= {CNT_WIDTH{1'b0}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_first <= 1'b1;
            blk_seq   <= {SEQID_WIDTH{1'b0}};
            blk_meta  <= {CNTRL_WIDTH{1'b0}};
            eob_lat   <= EOB_MIDDLE;
        end else begin
            if (accept && blk_first) begin
                blk_seq   <= in_seq_id;
                blk_meta  <= in_meta;
                blk_first <= 1'b0;
            end else if ((state == EOB_SEND) && pack_move) begin
                blk_first <= 1'b1;
            end
            if (accept && (in_eob != EOB_MIDDLE)) eob_lat <= in_eob;
        end
    end

    assign sc_is_vld    = out_vld;
    assign sc_is_sym0   = out_sym[0];
    assign sc_is_sym1   = out_sym[1];
    assign sc_is_sym2   = out_sym[2];
    assign sc_is_sym3   = out_sym[3];
    assign sc_is_cnt0   = out_cnt[0];
    assign sc_is_cnt1   = out_cnt[1];
    assign sc_is_cnt2   = out_cnt[2];
    assign sc_is_cnt3   = out_cnt[3];
    assign sc_is_seq_id = out_seq;
    assign sc_is_meta   = out_meta;
    assign sc_is_eob    = out_eob;
endmodule

// File: tb/tb_cr_huf_comp_sc_packer.sv
// Bench for cr_huf_comp_sc_packer: a block-level run-length/chunking model predicts every beat,
// one compare process checks transferred beats and stall stability, directed literals pin the model.
module tb_cr_huf_comp_sc_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld, in_rdy, is_sc_rd;
    logic [9:0] in_sym;
    logic [1:0] in_eob;
    logic [7:0] in_seq_id;
    logic       in_meta;
    logic [3:0] sc_is_vld;
    logic [9:0] sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3;
    logic [2:0] sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3;
    logic [7:0] sc_is_seq_id;
    logic       sc_is_meta;
    logic [1:0] sc_is_eob;

    always #5 clk = ~clk;

    cr_huf_comp_sc_packer dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_sym(in_sym),
        .in_eob(in_eob), .in_seq_id(in_seq_id), .in_meta(in_meta), .sc_is_vld(sc_is_vld),
        .sc_is_sym0(sc_is_sym0), .sc_is_sym1(sc_is_sym1), .sc_is_sym2(sc_is_sym2),
        .sc_is_sym3(sc_is_sym3), .sc_is_cnt0(sc_is_cnt0), .sc_is_cnt1(sc_is_cnt1),
        .sc_is_cnt2(sc_is_cnt2), .sc_is_cnt3(sc_is_cnt3), .sc_is_seq_id(sc_is_seq_id),
        .sc_is_meta(sc_is_meta), .sc_is_eob(sc_is_eob), .is_sc_rd(is_sc_rd)
    );

    typedef struct packed {
        logic [3:0]       vld;
        logic [3:0][9:0]  sym;
        logic [3:0][2:0]  cnt;
        logic [1:0]       eob;
        logic [7:0]       seq;
        logic             meta;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t seen[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    blk_syms[$];
    logic [7:0] blk_seq;
    logic       blk_meta;
    int    rd_mode = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic beat_t dut_beat();
        beat_t b;
        b.vld  = sc_is_vld;
        b.sym  = {sc_is_sym3, sc_is_sym2, sc_is_sym1, sc_is_sym0};
        b.cnt  = {sc_is_cnt3, sc_is_cnt2, sc_is_cnt1, sc_is_cnt0};
        b.eob  = sc_is_eob;
        b.seq  = sc_is_seq_id;
        b.meta = sc_is_meta;
        return b;
    endfunction

    // Block model: run-length encode with runs capped at 7, cut into groups of 4 lanes,
    // the last group carries the block's eob code.
    task automatic model_block(input logic [1:0] eob);
        int ls[$];
        int lc[$];
        beat_t b;
        foreach (blk_syms[i]) begin
            if (ls.size() > 0 && ls[$] == blk_syms[i] && lc[$] < 7) lc[$] = lc[$] + 1;
            else begin
                ls.push_back(blk_syms[i]);
                lc.push_back(1);
            end
        end
        for (int g = 0; g < ls.size(); g += 4) begin
            b = '0;
            for (int k = 0; k < 4; k++) begin
                if (g + k < ls.size()) begin
                    b.vld[k] = 1'b1;
                    b.sym[k] = 10'(ls[g+k]);
                    b.cnt[k] = 3'(lc[g+k]);
                end
            end
            b.eob  = (g + 4 >= ls.size()) ? eob : 2'd0;
            b.seq  = blk_seq;
            b.meta = blk_meta;
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_sym(input logic [9:0] s, input logic [1:0] e, input logic [7:0] sq,
                             input logic m);
        int n = 0;
        if (blk_syms.size() == 0) begin
            blk_seq  = sq;
            blk_meta = m;
        end
        blk_syms.push_back(int'(s));
        @(posedge clk); #1;
        in_vld = 1'b1; in_sym = s; in_eob = e; in_seq_id = sq; in_meta = m;
        @(negedge clk);
        while (!in_rdy && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("in_rdy_timeout", 128'(n), 128'd0);
        if (e != 2'd0) begin
            model_block(e);
            blk_syms.delete();
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || got_q.size() > 0) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("drain_done", 128'(exp_q.size() + got_q.size()), 128'd0);
    endtask

    // consumer ready pattern, changed just after the active edge
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0:       is_sc_rd = 1'b1;
            1:       is_sc_rd = 1'($urandom_range(0, 1));
            default: is_sc_rd = 1'b0;
        endcase
    end

    // single compare process: stall stability, then in-order beat matching against the model
    always @(negedge clk) begin
        beat_t cur;
        beat_t g;
        beat_t e;
        if (rst) prev_stall = 1'b0;
        else begin
            cur = dut_beat();
            if (prev_stall) chk("stall_hold", 128'(cur), 128'(prev_beat));
            if (|sc_is_vld && is_sc_rd) begin
                got_q.push_back(cur);
                seen.push_back(cur);
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                chk("beat", 128'(g), 128'(e));
            end
            prev_stall = |sc_is_vld && !is_sc_rd;
            prev_beat  = cur;
        end
    end

    initial begin
        int b;
        int left;
        logic [7:0] seq;
        rst = 1'b1; in_vld = 1'b0; in_sym = 10'd0; in_eob = 2'd0; in_seq_id = 8'd0;
        in_meta = 1'b0; is_sc_rd = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_vld", 128'(sc_is_vld), 128'd0);
        chk("rst_rdy", 128'(in_rdy), 128'd0);
        chk("rst_eob", 128'(sc_is_eob), 128'd0);
        chk("rst_sym0_seq", 128'({sc_is_sym0, sc_is_cnt0, sc_is_seq_id}), 128'd0);
        @(posedge clk); #1; rst = 1'b0;

        // T1: five distinct symbols
        b = seen.size();
        for (int i = 0; i < 5; i++)
            drive_sym(10'(10 + i), (i == 4) ? 2'd1 : 2'd0, 8'h21, 1'b1);
        idle();
        drain();
        chk("t1_beats", 128'(seen.size() - b), 128'd2);
        if (seen.size() - b == 2) begin
            chk("t1_b0_vld", 128'(seen[b].vld), 128'h1111 >> 0 & 128'hF | 128'd15);
            chk("t1_b0_sym", 128'(seen[b].sym), 128'({10'd13, 10'd12, 10'd11, 10'd10}));
            chk("t1_b0_cnt", 128'(seen[b].cnt), 128'({3'd1, 3'd1, 3'd1, 3'd1}));
            chk("t1_b0_eob", 128'(seen[b].eob), 128'd0);
            chk("t1_b1_vld", 128'(seen[b+1].vld), 128'd1);
            chk("t1_b1_sym", 128'({seen[b+1].sym[0], seen[b+1].cnt[0]}), 128'({10'd14, 3'd1}));
            chk("t1_b1_eob", 128'(seen[b+1].eob), 128'd1);
            chk("t1_seq", 128'({seen[b+1].seq, seen[b+1].meta}), 128'({8'h21, 1'b1}));
        end

        // T2: eleven repeats of 65
        b = seen.size();
        for (int i = 0; i < 11; i++) drive_sym(10'd65, (i == 10) ? 2'd2 : 2'd0, 8'h22, 1'b0);
        idle();
        drain();
        chk("t2_beats", 128'(seen.size() - b), 128'd1);
        if (seen.size() - b == 1) begin
            chk("t2_vld", 128'(seen[b].vld), 128'd3);
            chk("t2_lanes", 128'({seen[b].sym[1], seen[b].cnt[1], seen[b].sym[0], seen[b].cnt[0]}),
                128'({10'd65, 3'd4, 10'd65, 3'd7}));
            chk("t2_eob", 128'(seen[b].eob), 128'd2);
        end

        // T3: twelve distinct symbols against a 20-cycle stall
        b = seen.size();
        rd_mode = 2;
        fork
            begin
                repeat (20) @(negedge clk);
                chk("t3_rdy_blocked", 128'(in_rdy), 128'd0);
                chk("t3_out_held", 128'(sc_is_vld), 128'd15);
                rd_mode = 0;
            end
            begin
                for (int i = 0; i < 12; i++)
                    drive_sym(10'(100 + 7 * i), (i == 11) ? 2'd1 : 2'd0, 8'h23, 1'b1);
                idle();
            end
        join
        drain();
        chk("t3_beats", 128'(seen.size() - b), 128'd3);
        if (seen.size() - b == 3) begin
            chk("t3_first", 128'(seen[b].sym[0]), 128'd100);
            chk("t3_last", 128'({seen[b+2].vld, seen[b+2].sym[3], seen[b+2].eob}),
                128'({4'd15, 10'd177, 2'd1}));
        end

        // T4: single-symbol block followed immediately by another block
        b = seen.size();
        drive_sym(10'd300, 2'd1, 8'h05, 1'b0);
        drive_sym(10'd1, 2'd0, 8'h06, 1'b1);
        drive_sym(10'd2, 2'd2, 8'h77, 1'b0);
        idle();
        drain();
        chk("t4_beats", 128'(seen.size() - b), 128'd2);
        if (seen.size() - b == 2) begin
            chk("t4_b0", 128'({seen[b].vld, seen[b].sym[0], seen[b].cnt[0], seen[b].eob, seen[b].seq}),
                128'({4'd1, 10'd300, 3'd1, 2'd1, 8'h05}));
            chk("t4_b1_seq", 128'({seen[b+1].seq, seen[b+1].meta}), 128'({8'h06, 1'b1}));
        end

        // T5: reset with two packed lanes and an open run
        b = seen.size();
        drive_sym(10'd40, 2'd0, 8'h31, 1'b0);
        drive_sym(10'd41, 2'd0, 8'h31, 1'b0);
        drive_sym(10'd42, 2'd0, 8'h31, 1'b0);
        @(posedge clk); #1;
        in_vld = 1'b0; rst = 1'b1;
        blk_syms.delete();
        @(negedge clk);
        chk("t5_vld", 128'(sc_is_vld), 128'd0);
        chk("t5_eob_rdy", 128'({sc_is_eob, in_rdy}), 128'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_beat", 128'(seen.size() - b), 128'd0);
        drive_sym(10'd50, 2'd0, 8'h32, 1'b1);
        drive_sym(10'd50, 2'd1, 8'h32, 1'b1);
        idle();
        drain();

        // T6: random blocks with random consumer stalls
        rd_mode = 1;
        seq = 8'h40;
        left = $urandom_range(1, 40);
        for (int i = 0; i < 10000; i++) begin
            logic [9:0] s;
            s = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 3));
            if (left == 1 || i == 9999) begin
                drive_sym(s, 2'($urandom_range(1, 2)), 8'($urandom), 1'($urandom));
                seq = seq + 8'd1;
                left = $urandom_range(1, 40);
            end else begin
                drive_sym(s, 2'd0, (blk_syms.size() == 0) ? seq : 8'($urandom), 1'($urandom));
                left--;
            end
        end
        idle();
        drain();
        rd_mode = 0;
        repeat (3) @(negedge clk);
        chk("end_idle", 128'(sc_is_vld), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
